axi3_slave_memory: RTL and testbench
====================================

Name: axi3_slave_memory

Overview:
AXI3 slave responder: a word-addressed on-chip memory that answers read and write transactions from a 32-bit AXI3 master (HP-port style, 6-bit IDs, 4-bit burst length). It is the target end used to bring up and self-test our AXI masters in simulation and on fabric. Read and write channels are independent, with one outstanding transaction per direction.

Parameters:
DEPTH_LOG2, 10, memory depth of 2**DEPTH_LOG2 32-bit words
BASE_ADDR, 32'h0000_0000, byte base address, aligned to 4*2**DEPTH_LOG2

Ports:
clock  in  1  clock
reset  in  1  reset
awvalid/awready  in/out  1/1  write address handshake
awaddr  in  32  byte address
awlen  in  4  beats-1
awsize  in  3  beat size
awburst  in  2  burst type
awid  in  6  write ID
wvalid/wready  in/out  1/1  write data handshake
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last write beat
wid  in  6  write data ID
bvalid/bready  out/in  1/1  write response handshake
bresp  out  2  write response
bid  out  6  echoed awid
arvalid/arready  in/out  1/1  read address handshake
araddr  in  32  byte address
arlen  in  4  beats-1
arsize  in  3  beat size
arburst  in  2  burst type
arid  in  6  read ID
rvalid/rready  out/in  1/1  read data handshake
rdata  out  32  read data
rresp  out  2  read response
rid  out  6  echoed arid
rlast  out  1  last read beat

Behaviour:
- Reset: reset and clock as decided (reset synchronous, active-high; clock clock). Reset clears awready, wready, bvalid, arready, and rvalid to 0. bresp, rresp, and rlast are 0. bid and rid are 0. rdata is 0. Memory contents are not reset. Reset mid-burst abandons the burst; there is no partial response.
- Write FSM states:
  - W_IDLE: awready=1. On the AW handshake, latch id, index, len, and burst, compute the error code, then go to W_DATA.
  - W_DATA: wready=1. Each handshake writes mem[index] per byte under wstrb, unless the error code is nonzero, in which case the write is dropped. Index advances per burst type. On the beat where wlast=1 or the beat count reaches len (whichever comes first), go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id. Hold until bready, then return to W_IDLE.
- Write latencies: wready may assert the cycle after the AW handshake. bvalid asserts the cycle after the final W handshake.
- Write error cases:
  - wlast asserted before beat len: ends the burst early with SLVERR.
  - Beat len reached without wlast: also SLVERR.
  - wid != latched awid on any beat: SLVERR, and that beat's write is dropped.
- Read FSM states:
  - R_IDLE: arready=1. On the AR handshake, latch id, index, len, burst, and error code, issue a registered memory read, then go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rresp=error code, rlast=(beat==len).
    - On an rvalid&&rready handshake with rlast=0, advance the index and present the next beat the following cycle; rvalid stays high and beats are back-to-back.
    - On the handshake with rlast=1, return to R_IDLE.
  - rdata is 0 when the error code is nonzero.
- Read latency: the first rvalid asserts the cycle after the AR handshake.
- Error code, decided at the address phase, in priority order:
  - DECERR (2'b11): addr[31:2+DEPTH_LOG2] != BASE_ADDR[31:2+DEPTH_LOG2].
  - SLVERR (2'b10): size != 3'b010, or addr[1:0] != 0, or unsupported burst type.
  - Otherwise OKAY (2'b00).
  - EXOKAY is never returned; the lock, cache, prot, and qos fields are not ported.
- Burst address update:
  - INCR (2'b01): index = index+1 modulo 2**DEPTH_LOG2; a burst running past the top wraps to word 0.
  - FIXED (2'b00): index unchanged.
  - WRAP (2'b10): see Optional Feature.
  - 2'b11: SLVERR.
- Same-cycle read and write to the same word: the read returns the old data. The write is visible to reads issued one or more cycles later.
- Handshake rules: outputs never depend combinationally on same-cycle inputs. Once a valid is raised, it and its payload are held until the handshake completes.

Optional Feature:
- Macro: AXI3_SLAVE_MEMORY_WRAP_EN.
- Defined: WRAP bursts are supported.
  - Legal only for len in {1,3,7,15}; any other len gives SLVERR.
  - The index wraps within an aligned block of len+1 words: index = (index & ~len) | ((index+1) & len).
- Undefined: any WRAP burst gets SLVERR.
  - Write: all beats are still accepted and dropped.
  - Read: len+1 beats are returned with rdata=0.

Test Plan:
- Single write then single read:
  - Stimulus: AW addr 0x10, id 5, len 0, data 0xDEADBEEF, wstrb 4'hF; then AR addr 0x10.
  - Response: bresp 00, bid 5; rdata 0xDEADBEEF, rlast=1, rresp 00, rid 5.
- INCR burst:
  - Stimulus: write len 3 at 0x100 with 1,2,3,4; read back len 3 with rready held 1.
  - Response: rvalid continuous for 4 cycles with 1,2,3,4; rlast only on the 4th beat.
- Byte strobes and backpressure:
  - Stimulus: write 0xFFFFFFFF, then 0x00000000 with wstrb 4'b0101; read with rready toggled 1,0,1.
  - Response: rdata 0xFF00FF00, held stable while rready=0.
- Out-of-range read:
  - Stimulus: AR addr BASE_ADDR+0x1000 (DEPTH_LOG2=10), len 1.
  - Response: two beats, rresp 11, rdata 0.
- Out-of-range write, early wlast, and misalignment:
  - Stimulus: out-of-range write; separately, awlen 3 with wlast on beat 2; separately, araddr 0x2.
  - Response: DECERR with memory unchanged; SLVERR after beat 2; SLVERR.
- Reset mid-read and WRAP burst:
  - Stimulus: assert reset during beat 2 of a len 7 read; afterwards run a WRAP len 3 at 0x8.
  - Response: rvalid 0 the next cycle. With WRAP_EN the burst touches words 2,3,0,1 with OKAY; without it, SLVERR with 4 beats.

Source files
------------

// File: rtl/axi3_slave_memory.sv
// axi3_slave_memory
//   AXI3 slave responder backed by a word-addressed on-chip memory of
//   2**DEPTH_LOG2 32-bit words. It is used to bring up and self-test AXI
//   masters. The read and write channels are independent, and each allows
//   one outstanding transaction.
//
//   Build option: define AXI3_SLAVE_MEMORY_WRAP_EN to support WRAP bursts.
//   WRAP is then legal for len 1, 3, 7 and 15. Without the macro, every
//   WRAP burst gets SLVERR.
//
// Ports
//   clock, reset        clock, synchronous active-high reset
//   aw*                 write address channel (valid/ready, addr, len, size, burst, id)
//   w*                  write data channel (valid/ready, data, strb, last, id)
//   b*                  write response channel (valid/ready, resp, id)
//   ar*                 read address channel (valid/ready, addr, len, size, burst, id)
//   r*                  read data channel (valid/ready, data, resp, id, last)
//
// Handshake: a transfer happens on the rising edge where valid && ready.
// Every output here comes from registered state only. Once this block
// raises a valid, that valid and its payload stay stable until the matching
// ready is seen.
module axi3_slave_memory #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [5:0]  awid,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic [5:0]  wid,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [5:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [5:0]  arid,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [5:0]  rid,
    output logic        rlast
);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
`ifdef AXI3_SLAVE_MEMORY_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef logic [DEPTH_LOG2-1:0] index_t;

    logic [31:0] mem [DEPTH];

    // The response code is fixed at the address phase. DECERR takes
    // priority over SLVERR.
    function automatic logic [1:0] addr_error(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input logic [3:0] len);
        logic [1:0] code;
        logic       wrap_len_ok;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        code = RESP_OKAY;
        if (addr[31:2+DEPTH_LOG2] != BASE_ADDR[31:2+DEPTH_LOG2]) begin
            code = RESP_DECERR;
        end else if (size != 3'b010 || addr[1:0] != 2'b00) begin
            code = RESP_SLVERR;
        end else begin
            case (burst)
                BURST_FIXED, BURST_INCR: code = RESP_OKAY;
                BURST_WRAP: code = (WRAP_EN && wrap_len_ok) ? RESP_OKAY : RESP_SLVERR;
                default:    code = RESP_SLVERR;
            endcase
        end
        return code;
    endfunction

    // WRAP keeps the index inside an aligned block of len+1 words. When
    // len+1 is a power of two, the low bits of len act as the block mask.
    function automatic index_t next_index(input index_t index, input logic [1:0] burst,
                                          input logic [3:0] len);
        index_t mask;
        mask = index_t'(len);
        case (burst)
            BURST_INCR: return index + index_t'(1);
            BURST_WRAP: return (index & ~mask) | ((index + index_t'(1)) & mask);
            default:    return index;
        endcase
    endfunction

    // The address channels stay closed while reset is asserted and for
    // the first cycle after it is released.
    logic ready_en;
    always_ff @(posedge clock) begin
        if (reset) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    // ---------------- write side ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t w_state, w_state_next;

    logic [5:0]  w_id;
    index_t      w_index;
    logic [3:0]  w_len, w_beat;
    logic [1:0]  w_burst, w_err, bresp_q;
    logic        w_bad;
    logic        aw_fire, w_fire, w_final, w_id_ok, w_proto_err;

    assign aw_fire     = awvalid && awready;
    assign w_fire      = wvalid && wready;
    assign w_final     = wlast || (w_beat == w_len);
    assign w_id_ok     = (wid == w_id);
    // The burst is a protocol error if wlast does not land on beat len,
    // or if wid does not match the latched awid.
    assign w_proto_err = !w_id_ok || (wlast != (w_beat == w_len));

    always_comb begin
        w_state_next = w_state;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = ready_en;
                if (awvalid && ready_en) w_state_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_final) w_state_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_id    <= '0;
            w_index <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_burst <= '0;
            w_err   <= '0;
            w_bad   <= 1'b0;
            bresp_q <= '0;
        end else begin
            if (aw_fire) begin
                w_id    <= awid;
                w_index <= awaddr[DEPTH_LOG2+1:2];
                w_len   <= awlen;
                w_burst <= awburst;
                w_err   <= addr_error(awaddr, awsize, awburst, awlen);
                w_beat  <= '0;
                w_bad   <= 1'b0;
            end
            if (w_fire) begin
                w_index <= next_index(w_index, w_burst, w_len);
                w_beat  <= w_beat + 4'd1;
                if (w_proto_err) w_bad <= 1'b1;
                if (w_final) begin
                    if (w_err != RESP_OKAY)         bresp_q <= w_err;
                    else if (w_bad || w_proto_err)  bresp_q <= RESP_SLVERR;
                    else                            bresp_q <= RESP_OKAY;
                end
            end
        end
    end

    // Memory contents are not reset. A beat is dropped if the burst carries
    // an address-phase error or if its wid does not match.
    always_ff @(posedge clock) begin
        if (!reset && w_fire && w_err == RESP_OKAY && w_id_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_index][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign bresp = bresp_q;
    assign bid   = w_id;

    // ---------------- read side ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    r_state_t r_state, r_state_next;

    logic [5:0]  r_id;
    index_t      r_index, r_index_next;
    logic [3:0]  r_len, r_beat;
    logic [1:0]  r_burst, r_err;
    logic [31:0] rdata_q;
    logic        ar_fire, r_fire, r_done;

    assign ar_fire      = arvalid && arready;
    assign r_fire       = rvalid && rready;
    assign r_done       = (r_beat == r_len);
    assign r_index_next = next_index(r_index, r_burst, r_len);

    always_comb begin
        r_state_next = r_state;
        arready      = 1'b0;
        rvalid       = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = ready_en;
                if (arvalid && ready_en) r_state_next = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && r_done) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // rdata_q only loads on the AR handshake or on an accepted non-last
    // beat. It therefore holds under backpressure, and a write in the same
    // cycle is not visible until the next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_id    <= '0;
            r_index <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_burst <= '0;
            r_err   <= '0;
            rdata_q <= '0;
        end else if (ar_fire) begin
            r_id    <= arid;
            r_index <= araddr[DEPTH_LOG2+1:2];
            r_len   <= arlen;
            r_burst <= arburst;
            r_err   <= addr_error(araddr, arsize, arburst, arlen);
            r_beat  <= '0;
            rdata_q <= mem[araddr[DEPTH_LOG2+1:2]];
        end else if (r_fire && !r_done) begin
            r_index <= r_index_next;
            r_beat  <= r_beat + 4'd1;
            rdata_q <= mem[r_index_next];
        end
    end

    assign rdata = (r_err == RESP_OKAY) ? rdata_q : 32'd0;
    assign rresp = r_err;
    assign rid   = r_id;
    assign rlast = (r_state == R_DATA) && r_done;

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end
endmodule

// File: tb/tb_axi3_slave_memory.sv
// tb_axi3_slave_memory
//   Randomized bench for axi3_slave_memory with directed cases first.
//   The reference model is a plain word array. Expected responses and
//   burst address sequences are computed arithmetically from the
//   protocol rules.
`timescale 1ns/1ps
module tb_axi3_slave_memory;
    localparam int          DEPTH_LOG2 = 10;
    localparam int          DEPTH      = 1024;
    localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;
`ifdef AXI3_SLAVE_MEMORY_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic        clock, reset;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  awlen, wstrb;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic [5:0]  awid, wid, bid;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr, rdata;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic [5:0]  arid, rid;

    axi3_slave_memory #(.DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE_ADDR)) dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rid(rid), .rlast(rlast)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] model_err(input logic [31:0] addr, input logic [2:0] size,
                                             input logic [1:0] burst, input int len);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        if (off >= 32'(DEPTH * 4)) return 2'b11;
        if (size != 3'd2 || (addr % 4) != 0) return 2'b10;
        if (burst == 2'd0 || burst == 2'd1) return 2'b00;
        if (burst == 2'd2 && WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15)) return 2'b00;
        return 2'b10;
    endfunction

    function automatic int model_idx(input logic [31:0] addr, input logic [1:0] burst,
                                     input int len, input int beat);
        int base, n, start;
        base  = int'(((addr - BASE_ADDR) >> 2) % DEPTH);
        n     = len + 1;
        start = (base / n) * n;
        case (burst)
            2'd1:    return (base + beat) % DEPTH;
            2'd2:    return start + ((base - start + beat) % n);
            default: return base;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Each task starts and ends at a falling edge. Inputs change there and
    // outputs are sampled there.
    task automatic handshake(input string tag, input int which);
        int n;
        bit hs;
        n = 0;
        while (1) begin
            hs = (which == 0) ? awready : (which == 1) ? wready : arready;
            @(posedge clock);
            @(negedge clock);
            if (hs) break;
            n++;
            if (n > 50) begin
                check({tag, "_timeout"}, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [5:0] id,
                            input int last_beat, input int bad_beat);
        int         nbeats, n, k;
        logic [1:0] err, exp_resp;
        bit         proto;
        err      = model_err(addr, size, burst, len);
        nbeats   = ((last_beat < len) ? last_beat : len) + 1;
        proto    = (last_beat != len) || (bad_beat >= 0 && bad_beat < nbeats);
        exp_resp = (err != 2'b00) ? err : (proto ? 2'b10 : 2'b00);
        if (err == 2'b00) begin
            for (int i = 0; i < nbeats; i++) begin
                if (i != bad_beat) begin
                    k = model_idx(addr, burst, len, i);
                    for (int b = 0; b < 4; b++)
                        if (wr_strb[i][b]) ref_mem[k][8*b +: 8] = wr_data[i][8*b +: 8];
                end
            end
        end
        awvalid = 1'b1; awaddr = addr; awlen = 4'(len); awsize = size;
        awburst = burst; awid = id;
        handshake({tag, "_aw"}, 0);
        awvalid = 1'b0;
        check({tag, "_wready_lat"}, 32'(wready), 32'd1);
        for (int i = 0; i < nbeats; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clock);
            wvalid = 1'b1; wdata = wr_data[i]; wstrb = wr_strb[i];
            wlast  = (i == last_beat);
            wid    = (i == bad_beat) ? (id ^ 6'h01) : id;
            handshake({tag, "_w"}, 1);
            wvalid = 1'b0; wlast = 1'b0;
        end
        check({tag, "_bvalid_lat"}, 32'(bvalid), 32'd1);
        n = 0;
        while (!bvalid && n < 50) begin
            @(negedge clock);
            n++;
        end
        repeat ($urandom_range(0, 2)) @(negedge clock);
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        check({tag, "_bid"}, 32'(bid), 32'(id));
        bready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bready = 1'b0;
        check({tag, "_bvalid_done"}, 32'(bvalid), 32'd0);
    endtask

    // rmode: 0 = rready always 1, 1 = random, 2 = pattern 1,0,1,0...
    // abort_beat >= 0 asserts reset while that beat is presented.
    task automatic do_read(input string tag, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input logic [2:0] size, input logic [5:0] id,
                           input int rmode, input int abort_beat);
        int          beat, cyc;
        bit          held, r;
        logic [31:0] held_data, exp;
        logic [1:0]  err;
        err = model_err(addr, size, burst, len);
        exp_q.delete();
        for (int i = 0; i <= len; i++)
            exp_q.push_back((err != 2'b00) ? 32'd0 : ref_mem[model_idx(addr, burst, len, i)]);
        arvalid = 1'b1; araddr = addr; arlen = 4'(len); arsize = size;
        arburst = burst; arid = id;
        handshake({tag, "_ar"}, 2);
        arvalid = 1'b0;
        beat = 0; cyc = 0; held = 1'b0; held_data = '0;
        while (beat <= len && cyc < 100) begin
            check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
            if (held) check({tag, "_rdata_held"}, rdata, held_data);
            if (beat == abort_beat) begin
                reset = 1'b1;
                @(posedge clock);
                @(negedge clock);
                check({tag, "_rvalid_after_reset"}, 32'(rvalid), 32'd0);
                check({tag, "_arready_in_reset"}, 32'(arready), 32'd0);
                reset = 1'b0;
                rready = 1'b0;
                repeat (2) @(negedge clock);
                return;
            end
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 3) != 0) : (cyc % 2 == 0);
            rready = r;
            if (r) begin
                exp = exp_q.pop_front();
                check($sformatf("%s_rdata%0d", tag, beat), rdata, exp);
                check($sformatf("%s_rresp%0d", tag, beat), 32'(rresp), 32'(err));
                check($sformatf("%s_rid%0d", tag, beat), 32'(rid), 32'(id));
                check($sformatf("%s_rlast%0d", tag, beat), 32'(rlast), 32'(beat == len));
                beat++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                held_data = rdata;
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        rready = 1'b0;
        check({tag, "_rvalid_idle"}, 32'(rvalid), 32'd0);
    endtask

    task automatic fill_words(input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
        wr_data[0] = d0; wr_data[1] = d1; wr_data[2] = d2; wr_data[3] = d3;
        for (int i = 0; i < 16; i++) wr_strb[i] = 4'hF;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          len, last_beat, bad_beat;
        logic [1:0]  burst;
        logic [2:0]  size;
        reset = 1'b1;
        awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awid = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; wid = 0; bready = 0;
        arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arid = 0; rready = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_bid", 32'(bid), 32'd0);
        check("rst_rid", 32'(rid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Zero the whole memory so every later read has a known value.
        for (int i = 0; i < 16; i++) begin wr_data[i] = '0; wr_strb[i] = 4'hF; end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int blk = 0; blk < DEPTH / 16; blk++)
            do_write("init", 32'(blk * 64), 15, 2'd1, 3'd2, 6'(blk), 15, -1);

        fill_words(32'hDEADBEEF, 0, 0, 0);
        do_write("single_w", 32'h10, 0, 2'd1, 3'd2, 6'd5, 0, -1);
        do_read("single_r", 32'h10, 0, 2'd1, 3'd2, 6'd5, 0, -1);

        fill_words(32'd1, 32'd2, 32'd3, 32'd4);
        do_write("incr_w", 32'h100, 3, 2'd1, 3'd2, 6'd9, 3, -1);
        do_read("incr_r", 32'h100, 3, 2'd1, 3'd2, 6'd9, 0, -1);

        fill_words(32'hFFFFFFFF, 0, 0, 0);
        do_write("strb_w1", 32'h200, 0, 2'd1, 3'd2, 6'd1, 0, -1);
        wr_data[0] = 32'h0; wr_strb[0] = 4'b0101;
        do_write("strb_w2", 32'h200, 0, 2'd1, 3'd2, 6'd1, 0, -1);
        do_read("strb_r", 32'h200, 1, 2'd1, 3'd2, 6'd2, 2, -1);

        do_read("oor_r", BASE_ADDR + 32'h1000, 1, 2'd1, 3'd2, 6'd3, 0, -1);

        fill_words(32'h55555555, 32'h66666666, 0, 0);
        do_write("oor_w", BASE_ADDR + 32'h1040, 1, 2'd1, 3'd2, 6'd4, 1, -1);
        do_read("oor_chk", 32'h40, 1, 2'd1, 3'd2, 6'd4, 1, -1);
        fill_words(32'hA1, 32'hA2, 32'hA3, 32'hA4);
        do_write("early_wlast", 32'h300, 3, 2'd1, 3'd2, 6'd7, 2, -1);
        do_write("no_wlast", 32'h340, 1, 2'd1, 3'd2, 6'd7, 99, -1);
        do_write("bad_wid", 32'h380, 3, 2'd1, 3'd2, 6'd8, 3, 1);
        do_read("wr_err_chk", 32'h300, 3, 2'd1, 3'd2, 6'd7, 1, -1);
        do_read("bad_wid_chk", 32'h380, 3, 2'd1, 3'd2, 6'd8, 1, -1);
        do_read("misalign_r", 32'h2, 0, 2'd1, 3'd2, 6'd6, 0, -1);
        do_read("fixed_r", 32'h100, 2, 2'd0, 3'd2, 6'd6, 1, -1);

        do_read("reset_mid", 32'h100, 7, 2'd1, 3'd2, 6'd10, 0, 2);

        fill_words(32'h10, 32'h11, 32'h12, 32'h13);
        do_write("wrap_w", 32'h8, 3, 2'd2, 3'd2, 6'd11, 3, -1);
        do_read("wrap_r", 32'h8, 3, 2'd2, 3'd2, 6'd11, 0, -1);
        do_read("wrap_chk", 32'h0, 3, 2'd1, 3'd2, 6'd11, 0, -1);

        // The top of memory wraps to word 0.
        fill_words(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        do_write("top_w", 32'hFF8, 3, 2'd1, 3'd2, 6'd12, 3, -1);
        do_read("top_r", 32'hFF8, 3, 2'd1, 3'd2, 6'd12, 1, -1);

        for (int t = 0; t < 40; t++) begin
            a = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
            case ($urandom_range(0, 9))
                0: a = a + 32'h1000 * 32'($urandom_range(1, 3));
                1: a = a + 32'($urandom_range(1, 3));
                default: ;
            endcase
            len   = $urandom_range(0, 15);
            burst = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            if ($urandom_range(0, 1) == 0) begin
                last_beat = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 16) : len;
                bad_beat  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
                for (int i = 0; i < 16; i++) begin
                    wr_data[i] = $urandom;
                    wr_strb[i] = 4'($urandom_range(0, 15));
                end
                do_write("rnd_w", a, len, burst, size, 6'($urandom_range(0, 63)),
                         last_beat, bad_beat);
            end else begin
                do_read("rnd_r", a, len, burst, size, 6'($urandom_range(0, 63)), 1, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
